// File: rtl/reg_fault_monitor.sv
// Golden-snapshot fault monitor for a bank of asynchronous register bits.
// Optional macro REG_FAULT_TIMESTAMP_EN adds the free-running cycle counter feeding timestamp.
module reg_fault_monitor #(
  parameter int unsigned N_REGS        = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned TS_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              clear,
  input  logic [N_REGS-1:0] reg_in,
  output logic              fault,
  output logic [N_REGS-1:0] fault_mask,
  output logic [N_REGS-1:0] first_mask,
  output logic [CNT_W-1:0]  flip_count,
  output logic [1:0]        state,
  output logic [TS_W-1:0]   timestamp
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_SETTLE = 2'b01;
  localparam logic [1:0] S_ARMED  = 2'b10;

  logic [N_REGS-1:0] sync_q [SYNC_STAGES];
  logic [N_REGS-1:0] sync_d [SYNC_STAGES];
  logic [N_REGS-1:0] sync_w;

  logic [1:0]        state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [N_REGS-1:0] golden_q, golden_d;
  logic [N_REGS-1:0] prev_q, prev_d;
  logic              fault_q, fault_d;
  logic [N_REGS-1:0] fmask_q, fmask_d;
  logic [N_REGS-1:0] first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [TS_W-1:0]   cyc_now;
  logic [N_REGS-1:0] diff;
  logic              wipe;

  // Synchroniser chain for the asynchronous register outputs
  always_comb begin
    sync_d[0] = reg_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) sync_d[i] = sync_q[i-1];
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef REG_FAULT_TIMESTAMP_EN
  logic [TS_W-1:0] cyc_q, cyc_d;

  assign cyc_d   = cyc_q + TS_W'(1);
  assign cyc_now = cyc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end
`else
  assign cyc_now = '0;
`endif

  // Next-state and result update
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    golden_d = golden_q;
    prev_d   = prev_q;
    fault_d  = fault_q;
    fmask_d  = fmask_q;
    first_d  = first_q;
    cnt_d    = cnt_q;
    ts_d     = ts_q;
    wipe     = 1'b0;
    diff     = sync_w ^ golden_q;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d  = S_SETTLE;
          settle_d = '0;
          wipe     = 1'b1;
        end
      end
      S_SETTLE: begin
        if (arm) begin
          settle_d = '0;
          wipe     = 1'b1;
        end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          golden_d = sync_w;
          prev_d   = '0;
          state_d  = S_ARMED;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_ARMED: begin
        if (arm) begin
          state_d  = S_SETTLE;
          settle_d = '0;
          wipe     = 1'b1;
        end else begin
          if ((diff != '0) && !fault_q) begin
            fault_d = 1'b1;
            first_d = diff;
            ts_d    = cyc_now;
          end
          fmask_d = fmask_q | diff;
          // Only bits newly departing from golden count as an event
          if (((diff & ~prev_q) != '0) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
          prev_d = diff;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d  = S_IDLE;
      settle_d = '0;
      prev_d   = '0;
      wipe     = 1'b1;
    end

    if (wipe) begin
      fault_d = 1'b0;
      fmask_d = '0;
      first_d = '0;
      cnt_d   = '0;
      ts_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      state_q  <= S_IDLE;
      settle_q <= '0;
      golden_q <= '0;
      prev_q   <= '0;
      fault_q  <= 1'b0;
      fmask_q  <= '0;
      first_q  <= '0;
      cnt_q    <= '0;
      ts_q     <= '0;
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_d[i];
      state_q  <= state_d;
      settle_q <= settle_d;
      golden_q <= golden_d;
      prev_q   <= prev_d;
      fault_q  <= fault_d;
      fmask_q  <= fmask_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      ts_q     <= ts_d;
    end
  end

  assign fault      = fault_q;
  assign fault_mask = fmask_q;
  assign first_mask = first_q;
  assign flip_count = cnt_q;
  assign state      = state_q;
  assign timestamp  = ts_q;

endmodule

// File: tb/tb_reg_fault_monitor.sv
// Directed bench for reg_fault_monitor: vector table plus latency, timestamp and saturation sequences.
module tb_reg_fault_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm;
  logic        clear;
  logic [7:0]  reg_in;

  logic        fault, s_fault;
  logic [7:0]  fault_mask, first_mask, s_fmask, s_first;
  logic [15:0] flip_count;
  logic [3:0]  s_cnt;
  logic [1:0]  state, s_state;
  logic [31:0] timestamp, s_ts;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_fault_monitor u_dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clear), .reg_in(reg_in),
    .fault(fault), .fault_mask(fault_mask), .first_mask(first_mask),
    .flip_count(flip_count), .state(state), .timestamp(timestamp)
  );

  reg_fault_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clear), .reg_in(reg_in),
    .fault(s_fault), .fault_mask(s_fmask), .first_mask(s_first),
    .flip_count(s_cnt), .state(s_state), .timestamp(s_ts)
  );

`ifdef REG_FAULT_TIMESTAMP_EN
  logic [31:0] tb_cyc;
  always @(posedge clk) begin
    if (!reset_n) tb_cyc <= '0;
    else          tb_cyc <= tb_cyc + 32'd1;
  end
`endif

  typedef struct {
    logic        arm;
    logic        clr;
    logic [7:0]  rin;
    int          cyc;
    logic        e_fault;
    logic [7:0]  e_fm;
    logic [7:0]  e_first;
    logic [15:0] e_cnt;
    logic [1:0]  e_st;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input int i);
    arm    = tbl[i].arm;
    clear  = tbl[i].clr;
    reg_in = tbl[i].rin;
    repeat (tbl[i].cyc) @(posedge clk);
    @(negedge clk);
    arm   = 1'b0;
    clear = 1'b0;
    check($sformatf("v%0d_fault", i), 64'(fault),      64'(tbl[i].e_fault));
    check($sformatf("v%0d_fmask", i), 64'(fault_mask), 64'(tbl[i].e_fm));
    check($sformatf("v%0d_first", i), 64'(first_mask), 64'(tbl[i].e_first));
    check($sformatf("v%0d_cnt", i),   64'(flip_count), 64'(tbl[i].e_cnt));
    check($sformatf("v%0d_state", i), 64'(state),      64'(tbl[i].e_st));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] exp_ts;

  initial begin
    //        arm   clr   rin    cyc flt   fmask  first  cnt    state
    tbl[0]  = '{1'b0, 1'b0, 8'h3C, 3,  1'b0, 8'h00, 8'h00, 16'd0, 2'b00};
    tbl[1]  = '{1'b1, 1'b0, 8'h3C, 1,  1'b0, 8'h00, 8'h00, 16'd0, 2'b01};
    tbl[2]  = '{1'b0, 1'b0, 8'h3C, 15, 1'b0, 8'h00, 8'h00, 16'd0, 2'b01};
    tbl[3]  = '{1'b0, 1'b0, 8'h3C, 1,  1'b0, 8'h00, 8'h00, 16'd0, 2'b10};
    tbl[4]  = '{1'b0, 1'b0, 8'h3C, 5,  1'b0, 8'h00, 8'h00, 16'd0, 2'b10};
    tbl[5]  = '{1'b1, 1'b0, 8'h3C, 1,  1'b0, 8'h00, 8'h00, 16'd0, 2'b01};
    tbl[6]  = '{1'b0, 1'b0, 8'h3C, 16, 1'b0, 8'h00, 8'h00, 16'd0, 2'b10};
    tbl[7]  = '{1'b0, 1'b0, 8'hFC, 4,  1'b1, 8'hC0, 8'hC0, 16'd1, 2'b10};
    tbl[8]  = '{1'b0, 1'b0, 8'hFE, 4,  1'b1, 8'hC2, 8'hC0, 16'd2, 2'b10};
    tbl[9]  = '{1'b0, 1'b0, 8'h3C, 4,  1'b1, 8'hC2, 8'hC0, 16'd2, 2'b10};
    tbl[10] = '{1'b0, 1'b0, 8'hFC, 4,  1'b1, 8'hC2, 8'hC0, 16'd3, 2'b10};
    tbl[11] = '{1'b1, 1'b1, 8'hFC, 1,  1'b0, 8'h00, 8'h00, 16'd0, 2'b00};
    tbl[12] = '{1'b0, 1'b0, 8'h3C, 3,  1'b0, 8'h00, 8'h00, 16'd0, 2'b00};

    // Reset with a non-zero input pattern
    reset_n = 1'b0;
    arm     = 1'b0;
    clear   = 1'b0;
    reg_in  = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fault", 64'(fault),      64'd0);
    check("rst_fmask", 64'(fault_mask), 64'd0);
    check("rst_first", 64'(first_mask), 64'd0);
    check("rst_cnt",   64'(flip_count), 64'd0);
    check("rst_state", 64'(state),      64'd0);
    check("rst_ts",    64'(timestamp),  64'd0);
    reset_n = 1'b1;

    for (int i = 0; i <= 4; i++) run_vec(i);

    // Single-cycle glitch: fault rises exactly SYNC_STAGES+1 edges later
    reg_in = 8'h3D;
    step(1);
    check("lat_e1", 64'(fault), 64'd0);
    reg_in = 8'h3C;
    step(1);
    check("lat_e2", 64'(fault), 64'd0);
    step(1);
`ifdef REG_FAULT_TIMESTAMP_EN
    exp_ts = tb_cyc - 32'd1;
`else
    exp_ts = 32'd0;
`endif
    check("lat_e3",    64'(fault),      64'd1);
    check("lat_first", 64'(first_mask), 64'h01);
    check("lat_fmask", 64'(fault_mask), 64'h01);
    check("lat_cnt",   64'(flip_count), 64'd1);
    check("lat_ts",    64'(timestamp),  64'(exp_ts));
    step(5);
    check("lat_hold_cnt", 64'(flip_count), 64'd1);
    check("lat_hold_ts",  64'(timestamp),  64'(exp_ts));

    for (int i = 5; i <= 12; i++) run_vec(i);
    check("clr_ts", 64'(timestamp), 64'd0);

    // Saturation: 20 separate events, 4-bit counter pins at 4'hF
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(16);
    check("sat_armed", 64'(s_state), 64'h2);
    for (int k = 0; k < 20; k++) begin
      reg_in = 8'h3D;
      step(2);
      reg_in = 8'h3C;
      step(2);
    end
    step(4);
    check("sat_cnt4",  64'(s_cnt),      64'hF);
    check("sat_cnt16", 64'(flip_count), 64'd20);
    check("sat_fmask", 64'(s_fmask),    64'h01);
    check("sat_state", 64'(state),      64'h2);

    // Plain clear from ARMED
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_state", 64'(state),      64'd0);
    check("clr_cnt",   64'(flip_count), 64'd0);
    check("clr_fault", 64'(s_fault),    64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
